// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch control: sequences memory requests, holds redirects that
// arrive mid-fetch, and drives the two-level PC mux plus a fetch-ack watchdog.
module pc_fetch_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       br_taken,
  input  logic       j_req,
  input  logic       jr_req,
  input  logic       brk_req,
  input  logic       inst_ack,
  output logic       inst_req,
  output logic       pc_en,
  output logic [3:0] pc_sel,
  output logic       pc_first_sel,
  output logic       flush_if,
  output logic       inst_valid,
  output logic       fetch_timeout
);

  localparam logic [3:0] SelSeq  = 4'b0001;
  localparam logic [3:0] SelJ    = 4'b0010;
  localparam logic [3:0] SelJr   = 4'b0100;
  localparam logic [3:0] SelBrk  = 4'b1000;
  localparam logic [4:0] CntLast = 5'(TIMEOUT - 1);

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e     state_q, state_d;
  logic       pend_valid_q, pend_valid_d;
  logic [3:0] pend_sel_q, pend_sel_d;
  logic       pend_first_q, pend_first_d;
  logic [4:0] cnt_q, cnt_d;

  logic       cur_valid, cur_first;
  logic [3:0] cur_sel;
  logic       redirect, src_first;
  logic [3:0] src_sel;
  logic       lat_valid, lat_first;
  logic [3:0] lat_sel;

  // Highest-priority redirect requested this cycle.
  always_comb begin
    cur_valid = brk_req | jr_req | j_req | br_taken;
    cur_sel   = SelSeq;
    cur_first = 1'b0;
    if (brk_req) begin
      cur_sel = SelBrk;
    end else if (jr_req) begin
      cur_sel = SelJr;
    end else if (j_req) begin
      cur_sel = SelJ;
    end else if (br_taken) begin
      cur_first = 1'b1;
    end
  end

  // An older pending redirect wins; only a break may overwrite it.
  always_comb begin
    redirect  = pend_valid_q | cur_valid;
    src_sel   = pend_valid_q ? pend_sel_q : cur_sel;
    src_first = pend_valid_q ? pend_first_q : cur_first;
    lat_valid = pend_valid_q;
    lat_sel   = pend_sel_q;
    lat_first = pend_first_q;
    if (cur_valid && (!pend_valid_q || brk_req)) begin
      lat_valid = 1'b1;
      lat_sel   = cur_sel;
      lat_first = cur_first;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_sel_d    = pend_sel_q;
    pend_first_d  = pend_first_q;
    cnt_d         = cnt_q;
    inst_req      = 1'b0;
    pc_en         = 1'b0;
    pc_sel        = SelSeq;
    pc_first_sel  = 1'b0;
    flush_if      = 1'b0;
    inst_valid    = 1'b0;
    fetch_timeout = 1'b0;
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        inst_req = 1'b1;
        if (inst_ack) begin
          cnt_d      = '0;
          flush_if   = redirect;
          inst_valid = ~redirect;
          if (!stall) begin
            pc_en        = 1'b1;
            pc_sel       = src_sel;
            pc_first_sel = src_first;
            pend_valid_d = 1'b0;
          end else begin
            // Keep the redirect so the PC update on leaving HOLD uses it.
            pend_valid_d = lat_valid;
            pend_sel_d   = lat_sel;
            pend_first_d = lat_first;
            state_d      = StHold;
          end
        end else if (cnt_q == CntLast) begin
          pc_en         = 1'b1;
          pc_sel        = SelBrk;
          flush_if      = 1'b1;
          fetch_timeout = 1'b1;
          pend_valid_d  = 1'b0;
          cnt_d         = '0;
        end else begin
          cnt_d        = cnt_q + 5'd1;
          pend_valid_d = lat_valid;
          pend_sel_d   = lat_sel;
          pend_first_d = lat_first;
        end
      end
      StHold: begin
        cnt_d = '0;
        if (!stall) begin
          pc_en        = 1'b1;
          pc_sel       = src_sel;
          pc_first_sel = src_first;
          pend_valid_d = 1'b0;
          state_d      = StFetch;
        end else begin
          pend_valid_d = lat_valid;
          pend_sel_d   = lat_sel;
          pend_first_d = lat_first;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBoot;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= SelSeq;
      pend_first_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
      pend_first_q <= pend_first_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each driven cycle queues its expected
// output vector; a negedge monitor pops and compares.
module tb_pc_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset, stall, br_taken, j_req, jr_req, brk_req, inst_ack;
  logic       inst_req, pc_en, pc_first_sel, flush_if, inst_valid, fetch_timeout;
  logic [3:0] pc_sel;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [9:0] v;
  } exp_t;
  exp_t sb_q[$];

  pc_fetch_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br_taken     (br_taken),
    .j_req        (j_req),
    .jr_req       (jr_req),
    .brk_req      (brk_req),
    .inst_ack     (inst_ack),
    .inst_req     (inst_req),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .pc_first_sel (pc_first_sel),
    .flush_if     (flush_if),
    .inst_valid   (inst_valid),
    .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  // Vector layout: {inst_req, pc_en, pc_sel[3:0], pc_first_sel, flush_if, inst_valid, timeout}
  function automatic logic [9:0] ev(logic rq, logic en, logic [3:0] sel, logic fs, logic fl,
                                    logic vl, logic to);
    return {rq, en, sel, fs, fl, vl, to};
  endfunction

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, {inst_req, pc_en, pc_sel, pc_first_sel, flush_if, inst_valid,
                       fetch_timeout}, e.v);
    end
  end

  // ins = {stall, br_taken, j_req, jr_req, brk_req, inst_ack}
  task automatic cyc(input string tag, input logic [5:0] ins, input logic [9:0] exp);
    exp_t e;
    {stall, br_taken, j_req, jr_req, brk_req, inst_ack} = ins;
    e.tag = tag;
    e.v   = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] INone = 6'b000000;
  localparam logic [5:0] IAck  = 6'b000001;
  localparam logic [5:0] IBrk  = 6'b000010;
  localparam logic [5:0] IJr   = 6'b000100;
  localparam logic [5:0] IJ    = 6'b001000;
  localparam logic [5:0] IBr   = 6'b010000;
  localparam logic [5:0] IStl  = 6'b100000;

  logic [9:0] e_boot, e_idle, e_seq, e_hold;

  initial begin
    e_boot = ev(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    e_idle = ev(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    e_seq  = ev(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
    e_hold = ev(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    {stall, br_taken, j_req, jr_req, brk_req, inst_ack} = INone;
    @(posedge clk);
    #1;
    cyc("reset_boot", IAck, e_boot);
    reset = 1'b0;
    cyc("boot_cycle1", IAck, e_boot);
    for (int i = 0; i < 4; i++) cyc("seq_ack", IAck, e_seq);

    cyc("j_br_ack", IJ | IBr | IAck, ev(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("after_j_seq", IAck, e_seq);

    cyc("br_pulse", IBr, e_idle);
    cyc("br_wait1", INone, e_idle);
    cyc("br_wait2", INone, e_idle);
    cyc("br_update", IAck, ev(1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0));
    cyc("br_next_seq", IAck, e_seq);

    cyc("jr_pend", IJr, e_idle);
    cyc("brk_replace", IBrk, e_idle);
    cyc("brk_update", IAck, ev(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("brk_pend", IBrk, e_idle);
    cyc("j_no_replace", IJ, e_idle);
    cyc("brk_kept", IAck, ev(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("j_pend", IJ, e_idle);
    cyc("br_no_replace", IBr, e_idle);
    cyc("j_kept", IAck, ev(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("redir_then_seq", IAck, e_seq);

    cyc("stall_ack", IStl | IAck, ev(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) cyc("hold_stall", IStl, e_hold);
    cyc("hold_release", INone, ev(1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("fetch_after_hold", IAck, e_seq);

    cyc("stall_ack_jr", IStl | IJr | IAck, ev(1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0));
    cyc("hold_jr_stall", IStl, e_hold);
    cyc("hold_jr_release", INone, ev(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc("fetch_after_jr", IAck, e_seq);

    for (int i = 0; i < 15; i++) cyc("wd_wait", INone, e_idle);
    cyc("wd_expire", INone, ev(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc("wd_after", INone, e_idle);
    cyc("wd_after2", INone, e_idle);

    reset = 1'b1;
    cyc("reset_mid_fetch", INone, e_idle);
    reset = 1'b0;
    cyc("boot_after_reset", IAck, e_boot);
    cyc("fetch_after_reset", IAck, e_seq);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
